// File: rtl/pooling_kxk_stream.sv
// Streaming KxK pooling (stride K) over an IMG_N x IMG_N raster-order image of signed pixels.
// Define POOL_MAX_EN to honour `mode` (max pooling); otherwise averaging is always used.
module pooling_kxk_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_N  = 28,
    parameter int POOL_K = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] pixel_out,
    output logic              finish
);
    localparam int LOG_K = $clog2(POOL_K);
    localparam int ACC_W = DATA_W + 2 * LOG_K;
    localparam int NWIN  = IMG_N / POOL_K;
    localparam int LIM   = NWIN * POOL_K;
    localparam int CW    = $clog2(IMG_N + 1);
    localparam int IW    = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int unsigned NACC = 1 << IW;
    localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(POOL_K * POOL_K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]           row, col;
    logic signed [ACC_W-1:0] acc [NACC];
    logic                    accept, last_pix, in_win, win_first, win_last;
    logic [IW-1:0]           win_idx;
    logic signed [ACC_W-1:0] pix_ext, cur, upd, biased;
    logic [DATA_W-1:0]       avg_res, result;

`ifdef POOL_MAX_EN
    logic mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else if (state == IDLE && start)
            mode_q <= mode;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (accept && last_pix) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == RUN) && pixel_valid;
        last_pix  = (row == CW'(IMG_N - 1)) && (col == CW'(IMG_N - 1));
        in_win    = (row < CW'(LIM)) && (col < CW'(LIM));
        win_first = (row[LOG_K-1:0] == '0) && (col[LOG_K-1:0] == '0);
        win_last  = (row[LOG_K-1:0] == '1) && (col[LOG_K-1:0] == '1);
        win_idx   = IW'(col >> LOG_K);
        pix_ext   = ACC_W'($signed(pixel_in));
        cur       = acc[win_idx];
    end

    // Negative sums get a K*K-1 bias before the shift so the quotient truncates toward zero.
    always_comb begin
        upd = cur + pix_ext;
`ifdef POOL_MAX_EN
        if (mode_q) upd = (pix_ext > cur) ? pix_ext : cur;
`endif
        if (win_first) upd = pix_ext;
        biased  = upd + (upd[ACC_W-1] ? BIAS : '0);
        avg_res = DATA_W'(biased >>> (2 * LOG_K));
        result  = avg_res;
`ifdef POOL_MAX_EN
        if (mode_q) result = upd[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            pixel_out <= '0;
            for (int unsigned i = 0; i < NACC; i++) acc[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE && start) begin
                row <= '0;
                col <= '0;
                for (int unsigned i = 0; i < NACC; i++) acc[i] <= '0;
            end else if (accept) begin
                if (col == CW'(IMG_N - 1)) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (in_win) begin
                    acc[win_idx] <= upd;
                    if (win_last) begin
                        out_valid <= 1'b1;
                        pixel_out <= result;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pooling_kxk_stream.sv
// Self-checking bench for pooling_kxk_stream: four geometries, per-cycle model compare plus literal pins.
`timescale 1ns/1ps
module tb_pooling_kxk_stream;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [NI];
    logic        mode  [NI];
    logic        pv    [NI];
    logic [15:0] pin   [NI];
    logic        busy  [NI];
    logic        ov    [NI];
    logic        fin   [NI];
    logic [15:0] pout  [NI];

    logic e_busy [NI];
    logic e_ov   [NI];
    logic e_fin  [NI];
    int   e_val  [NI];
    int   fin_cyc [NI];

    int img [32];
    int capq [$];
    int act = 0;
    int cyc = 0;
    int st_cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    pooling_kxk_stream #(.DATA_W(16), .IMG_N(4), .POOL_K(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .pixel_valid(pv[0]),
        .pixel_in(pin[0]), .busy(busy[0]), .out_valid(ov[0]), .pixel_out(pout[0]), .finish(fin[0]));
    pooling_kxk_stream #(.DATA_W(16), .IMG_N(2), .POOL_K(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .pixel_valid(pv[1]),
        .pixel_in(pin[1]), .busy(busy[1]), .out_valid(ov[1]), .pixel_out(pout[1]), .finish(fin[1]));
    pooling_kxk_stream #(.DATA_W(16), .IMG_N(5), .POOL_K(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]), .pixel_valid(pv[2]),
        .pixel_in(pin[2]), .busy(busy[2]), .out_valid(ov[2]), .pixel_out(pout[2]), .finish(fin[2]));
    pooling_kxk_stream #(.DATA_W(16), .IMG_N(4), .POOL_K(4)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode[3]), .pixel_valid(pv[3]),
        .pixel_in(pin[3]), .busy(busy[3]), .out_valid(ov[3]), .pixel_out(pout[3]), .finish(fin[3]));

    function automatic int n_of(input int id);
        case (id)
            0: return 4;
            1: return 2;
            2: return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int k_of(input int id);
        return (id == 3) ? 4 : 2;
    endfunction

    // Reference result of window (wr, wc): plain sum/max over the image; int '/' truncates toward zero.
    function automatic int win_result(input int n, input int k, input bit mx, input int wr, input int wc);
        int s, m, v;
        s = 0;
        m = img[wr * k * n + wc * k];
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++) begin
                v = img[(wr * k + i) * n + wc * k + j];
                s += v;
                if (v > m) m = v;
            end
        return mx ? m : s / (k * k);
    endfunction

    task automatic chk(input string nm, input int id, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0d, expected %0d (cycle %0d)", nm, id, got, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            chk("busy", i, int'(busy[i]), int'(e_busy[i]));
            chk("out_valid", i, int'(ov[i]), int'(e_ov[i]));
            chk("finish", i, int'(fin[i]), int'(e_fin[i]));
            if (e_ov[i]) chk("pixel_out", i, int'($signed(pout[i])), e_val[i]);
            if (ov[i] && i == act) capq.push_back(int'($signed(pout[i])));
            if (fin[i]) fin_cyc[i] = cyc;
        end
    end

    task automatic run_image(input int id, input bit md, input int gap_pct, input int mid_start,
                             input int abort_at);
        int n, k, lim, idx, guard, r, c, target;
        bit v, mx;
        n = n_of(id);
        k = k_of(id);
        lim = (n / k) * k;
        target = (abort_at > 0) ? abort_at : n * n;
`ifdef POOL_MAX_EN
        mx = md;
`else
        mx = 1'b0;
`endif
        act = id;
        capq.delete();
        @(negedge clk);
        start[id] = 1'b1;
        mode[id] = md;
        pv[id] = 1'b0;
        e_busy[id] = 1'b1;
        e_ov[id] = 1'b0;
        e_fin[id] = 1'b0;
        st_cyc = cyc;
        idx = 0;
        guard = 0;
        while (idx < target && guard < 2000) begin
            @(negedge clk);
            guard++;
            v = ($urandom_range(99) >= gap_pct);
            start[id] = (idx == mid_start);
            mode[id] = ~md;
            pv[id] = v;
            pin[id] = v ? 16'(img[idx]) : 16'($urandom);
            e_ov[id] = 1'b0;
            e_fin[id] = 1'b0;
            if (v) begin
                r = idx / n;
                c = idx % n;
                if (r < lim && c < lim && r % k == k - 1 && c % k == k - 1) begin
                    e_ov[id] = 1'b1;
                    e_val[id] = win_result(n, k, mx, r / k, c / k);
                end
                if (idx == n * n - 1) e_fin[id] = 1'b1;
                idx++;
            end
        end
        chk("pixels_sent", id, idx, target);
        @(negedge clk);
        start[id] = 1'b0;
        pv[id] = 1'b0;
        e_ov[id] = 1'b0;
        e_fin[id] = 1'b0;
        if (abort_at <= 0) begin
            e_busy[id] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_lits(input string nm, input int id, input int cnt, input int l0, input int l1,
                            input int l2, input int l3);
        int lit [4];
        lit[0] = l0; lit[1] = l1; lit[2] = l2; lit[3] = l3;
        chk({nm, "_count"}, id, capq.size(), cnt);
        for (int i = 0; i < cnt; i++)
            chk(nm, id, (i < capq.size()) ? capq[i] : -99999, lit[i]);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; mode[i] = 1'b0; pv[i] = 1'b0; pin[i] = '0;
            e_busy[i] = 1'b0; e_ov[i] = 1'b0; e_fin[i] = 1'b0; e_val[i] = 0; fin_cyc[i] = -1;
        end
        #3;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, int'(busy[i]), 0);
            chk("rst_out_valid", i, int'(ov[i]), 0);
            chk("rst_pixel_out", i, int'(pout[i]), 0);
            chk("rst_finish", i, int'(fin[i]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) img[i] = i;
        run_image(0, 1'b0, 0, -1, 0);
        chk_lits("avg4", 0, 4, 2, 4, 10, 12);
        chk("finish_latency", 0, fin_cyc[0] - st_cyc, 17);
        run_image(0, 1'b1, 0, -1, 0);
`ifdef POOL_MAX_EN
        chk_lits("max4", 0, 4, 5, 7, 13, 15);
`else
        chk_lits("max4", 0, 4, 2, 4, 10, 12);
`endif

        for (int i = 0; i < 4; i++) img[i] = -(i + 1);
        run_image(1, 1'b0, 0, -1, 0);
        chk_lits("neg_avg", 1, 1, -2, 0, 0, 0);
        run_image(1, 1'b1, 0, -1, 0);
`ifdef POOL_MAX_EN
        chk_lits("neg_max", 1, 1, -1, 0, 0, 0);
`else
        chk_lits("neg_max", 1, 1, -2, 0, 0, 0);
`endif

        for (int i = 0; i < 25; i++) img[i] = i;
        run_image(2, 1'b0, 0, -1, 0);
        chk_lits("odd5", 2, 4, 3, 5, 13, 15);
        chk("finish_latency", 2, fin_cyc[2] - st_cyc, 26);

        repeat (4) begin
            for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(65535)) - 32768;
            run_image(3, 1'($urandom_range(1)), 30, 5, 0);
            chk("k4_count", 3, capq.size(), 1);
        end

        for (int i = 0; i < 16; i++) img[i] = i;
        run_image(0, 1'b0, 0, -1, 6);
        for (int i = 0; i < NI; i++) begin
            e_busy[i] = 1'b0; e_ov[i] = 1'b0; e_fin[i] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 0, int'(busy[0]), 0);
        chk("midrst_out_valid", 0, int'(ov[0]), 0);
        chk("midrst_pixel_out", 0, int'(pout[0]), 0);
        chk("midrst_finish", 0, int'(fin[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(2000)) - 1000;
        run_image(0, 1'b0, 30, -1, 0);
        chk("post_rst_count", 0, capq.size(), 4);
        run_image(0, 1'b1, 30, 7, 0);

        repeat (3) begin
            for (int i = 0; i < 25; i++) img[i] = int'($urandom_range(65535)) - 32768;
            run_image(2, 1'($urandom_range(1)), 20, -1, 0);
            chk("odd5_count", 2, capq.size(), 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pooling_kxk_stream.md
# pooling_kxk_stream

Streaming, parametrised K×K pooling unit: the next-generation successor to the fixed 2×2 combinational pooling block. It accepts an IMG_N×IMG_N image of signed pixels one per cycle in raster order. It produces one pooled pixel per non-overlapping K×K window, using either average or max mode, with stride K. It sits between a convolution layer's output stream and the next layer's input buffer, and keeps the `start`/`finish` handshake of the existing pooling blocks.

## Interface
- `DATA_W`, 16, pixel width (signed, two's complement)
- `IMG_N`, 28, image side length in pixels (≥ POOL_K)
- `POOL_K`, 2, window side and stride; legal values 2, 4
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse that begins a new image; ignored while busy
- `mode`  in  1  0 = average, 1 = max; sampled on the `start` cycle
- `pixel_valid`  in  1  `pixel_in` is valid this cycle
- `pixel_in`  in  DATA_W  input pixel, raster order (row-major)
- `busy`  out  1  image in progress
- `out_valid`  out  1  `pixel_out` valid, one-cycle pulse per pooled pixel
- `pixel_out`  out  DATA_W  pooled pixel
- `finish`  out  1  one-cycle pulse after the last input pixel is consumed

## Operation
- FSM states:
  - IDLE: `busy` = 0; `start` latches `mode`, clears counters and accumulators, moves to RUN.
  - RUN: `busy` = 1; consumes pixels; moves to DONE after pixel (IMG_N−1, IMG_N−1) is accepted.
  - DONE: `finish` = 1 for one cycle, then IDLE.
- Pixels are accepted only in RUN with `pixel_valid` = 1; `pixel_valid` outside RUN is ignored. Gaps (`pixel_valid` = 0) stall all counters.
- Counters `row` and `col` run over 0..IMG_N−1, with column wrap-around incrementing `row`.
- There are IMG_N/POOL_K accumulators, one per window column. Each is cleared when the first pixel of its window arrives, i.e. (`row` % K == 0, `col` % K == 0).
- Average mode: accumulator width is DATA_W + 2·log2(POOL_K), signed. The result is sum / (K·K) with truncation toward zero, matching SV signed `/`; an arithmetic shift alone is not acceptable for negatives.
- Max mode: the accumulator holds the signed running maximum.
- A window completes on acceptance of pixel (`row` % K == K−1, `col` % K == K−1). The next cycle, `out_valid` = 1 and `pixel_out` holds the result.
- IMG_N not a multiple of K: trailing rows and columns beyond floor(IMG_N/K)·K are consumed but contribute to no output.
- Output count per image = (IMG_N/K)², integer division.
- `start` during RUN or DONE is ignored; `mode` is not re-sampled.
- `rst_n` low at any time, including mid-image, forces IDLE immediately and clears counters, accumulators and all outputs. No partial window is emitted.

## Timing
- Reset values: `busy` = 0, `out_valid` = 0, `pixel_out` = 0, `finish` = 0.
- `busy` rises the cycle after `start`.
- Latency is 1 cycle from the acceptance edge of a window's last pixel to `out_valid`.
- `finish` is asserted the cycle after the final pixel is accepted. When IMG_N % K == 0 it coincides with the last `out_valid`.
- `busy` falls together with `finish` deasserting. A new `start` is accepted in the first IDLE cycle.
- Throughput: 1 pixel/cycle sustained with no back-pressure; the downstream block must accept every `out_valid`.

## Configuration
- `POOL_MAX_EN` defined: `mode` is honoured and max-mode logic is built.
- `POOL_MAX_EN` undefined: `mode` is ignored, no comparators are synthesised, and average mode is always used.

## Test plan
- Average, IMG_N=4, K=2, pixels 0..15 in raster order, continuous valid -> `out_valid` pulses with 2, 4, 10, 12. `finish` coincides with the 4th pulse, 17 cycles after `start`.
- Max (`POOL_MAX_EN` defined), same image, `mode`=1 -> outputs 5, 7, 13, 15. With the macro undefined -> 2, 4, 10, 12.
- Negatives, IMG_N=2, K=2, pixels −1, −2, −3, −4 -> average −2 (−10/4 truncated toward zero); max −1.
- IMG_N=5, K=2, pixels 0..24 -> exactly 4 outputs: 3, 5, 13, 15. `finish` 1 cycle after the 25th pixel, with no `out_valid` on that cycle.
- Random `pixel_valid` gaps (~30 % low), IMG_N=4, K=4, random pixels -> single output equal to the truncated mean of 16 pixels. A `start` pulsed mid-image is ignored.
- `rst_n` pulsed low after 6 pixels of an IMG_N=4 image -> all outputs 0 and IDLE the same cycle. A following full image yields correct results with no stale accumulator data.
